// File: rtl/tlul_cmd_host_pkg.sv
// rtl/tlul_cmd_host_pkg.sv - response codes, FSM states and constants for tlul_cmd_host
package tlul_cmd_host_pkg;

  typedef enum logic [2:0] {
    ErrOk       = 3'd0,
    ErrBus      = 3'd1,
    ErrProto    = 3'd2,
    ErrTimeout  = 3'd3,
    ErrMisalign = 3'd4
  } err_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StRsp
  } state_e;

  localparam logic [1:0] SizeWord = 2'd2;

endpackage

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel types, opcodes and instruction-type encodings
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  localparam logic [3:0] MuBi4False     = 4'h9;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// rtl/tlul_cmd_intg_gen.sv - fills A-channel command and data integrity into a_user
module tlul_cmd_intg_gen
  import tlul_pkg::*;
(
  input  tl_h2d_t tl_i,
  output tl_h2d_t tl_o
);

  // Seven-bit folded parity, inverted so an all-zero beat never carries all-zero integrity.
  logic [48:0] cmd_bits;
  logic [34:0] data_bits;
  logic [6:0]  cmd_intg;
  logic [6:0]  data_intg;

  assign cmd_bits  = {6'b0, tl_i.a_user.instr_type, tl_i.a_address, tl_i.a_opcode, tl_i.a_mask};
  assign data_bits = {3'b0, tl_i.a_data};

  assign cmd_intg  = ~(cmd_bits[6:0] ^ cmd_bits[13:7] ^ cmd_bits[20:14] ^ cmd_bits[27:21] ^
                       cmd_bits[34:28] ^ cmd_bits[41:35] ^ cmd_bits[48:42]);
  assign data_intg = ~(data_bits[6:0] ^ data_bits[13:7] ^ data_bits[20:14] ^
                       data_bits[27:21] ^ data_bits[34:28]);

  always_comb begin
    tl_o = tl_i;
    tl_o.a_user.cmd_intg  = cmd_intg;
    tl_o.a_user.data_intg = data_intg;
  end

endmodule

// File: rtl/tlul_cmd_host.sv
// rtl/tlul_cmd_host.sv - single-outstanding TL-UL initiator driven by a valid/ready command port
module tlul_cmd_host
  import tlul_pkg::*;
  import tlul_cmd_host_pkg::*;
#(
  parameter logic [7:0]  SourceId      = 8'h00,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntW          = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic [2:0]  rsp_err_o,
  output logic        busy_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  state_e          state_q, state_d;
  err_e            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            write_q;
  logic [31:0]     addr_q, wdata_q;
  logic [3:0]      be_q;
  logic            cmd_hs, timeout, d_proto, a_valid, d_ready;
  logic [2:0]      exp_d_op;
  tl_h2d_t         tl_pre;
  logic            unused_d;

  assign unused_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink};

  // Reset gates ready so no command is taken while the block is held in reset.
  assign cmd_ready_o = rst_ni & (state_q == StIdle);
  assign cmd_hs      = cmd_valid_i & cmd_ready_o;
  assign rsp_valid_o = (state_q == StRsp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = (state_q != StIdle);

  assign exp_d_op = write_q ? AccessAck : AccessAckData;
  assign d_proto  = (tl_i.d_source != SourceId) | (tl_i.d_opcode != exp_d_op);
  assign timeout  = (TimeoutCycles != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    a_valid = 1'b0;
    d_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Always ready here so responses arriving after a timeout are drained.
        d_ready = 1'b1;
        if (cmd_hs) begin
          if (cmd_addr_i[1:0] != 2'b00) begin
            state_d = StRsp;
            err_d   = ErrMisalign;
            rdata_d = '0;
          end else begin
            state_d = StReq;
            cnt_d   = '0;
          end
        end
      end
      StReq, StWait: begin
        a_valid = (state_q == StReq);
        d_ready = 1'b1;
        cnt_d   = cnt_q + CntW'(1);
        // A response wins over a timeout expiring in the same cycle.
        if (tl_i.d_valid) begin
          state_d = StRsp;
          if (d_proto) begin
            err_d   = ErrProto;
            rdata_d = '0;
          end else if (tl_i.d_error) begin
            err_d   = ErrBus;
            rdata_d = '0;
          end else begin
            err_d   = ErrOk;
            rdata_d = write_q ? '0 : tl_i.d_data;
          end
        end else if (timeout) begin
          state_d = StRsp;
          err_d   = ErrTimeout;
          rdata_d = '0;
        end else if ((state_q == StReq) && tl_i.a_ready) begin
          state_d = StWait;
        end
      end
      StRsp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      err_q   <= ErrOk;
      rdata_q <= '0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      if (cmd_hs) begin
        write_q <= cmd_write_i;
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
        be_q    <= cmd_be_i;
      end
    end
  end

  always_comb begin
    tl_pre           = '0;
    tl_pre.a_valid   = a_valid;
    tl_pre.a_opcode  = !write_q ? Get : ((be_q == 4'hF) ? PutFullData : PutPartialData);
    tl_pre.a_size    = SizeWord;
    tl_pre.a_source  = SourceId;
    tl_pre.a_address = addr_q;
    tl_pre.a_mask    = write_q ? be_q : 4'hF;
    tl_pre.a_data    = write_q ? wdata_q : '0;
    tl_pre.a_user.instr_type = MuBi4False;
    tl_pre.d_ready   = d_ready;
  end

  tlul_cmd_intg_gen u_intg_gen (
    .tl_i (tl_pre),
    .tl_o (tl_o)
  );

endmodule

// File: tb/tb_tlul_cmd_host.sv
// tb/tb_tlul_cmd_host.sv - directed bench for tlul_cmd_host against a behavioural TL-UL responder
module tb_tlul_cmd_host;
  import tlul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_err;
  logic        busy;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  always #5 clk = ~clk;

  tlul_cmd_host #(
    .SourceId      (8'h00),
    .TimeoutCycles (16),
    .CntW          (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_be_i    (cmd_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .tl_o        (tl_o),
    .tl_i        (tl_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Responder configuration and observation state
  logic [31:0] mem [0:63];
  int          stall_cfg = 0;
  int          stall_left = 0;
  bit          no_resp = 0;
  bit          resp_err = 0;
  logic [7:0]  resp_src = 8'h00;
  bit          inject_late = 0;
  bit          a_fire = 0, d_fire = 0, d_fire_idle = 0, prev_stall = 0, prev_av = 0;
  int          a_beats = 0, av_cycles = 0, a_unstable = 0, d_drained = 0;
  logic [2:0]  last_op;
  logic [3:0]  last_mask;
  logic [1:0]  last_size;
  logic [7:0]  last_src;
  logic [3:0]  last_itype;
  logic [31:0] fire_addr, fire_data;
  logic [108:0] prev_a;
  logic [108:0] cur_a;

  always @(negedge clk) begin
    if (!rst_n) begin
      tl_i = '0;
      a_fire = 0; d_fire = 0; d_fire_idle = 0; prev_stall = 0; prev_av = 0;
      stall_left = 0;
    end else begin
      if (d_fire) begin
        tl_i.d_valid = 1'b0;
        if (d_fire_idle) d_drained++;
      end
      if (a_fire && !no_resp) begin
        tl_i.d_valid  = 1'b1;
        tl_i.d_source = resp_src;
        tl_i.d_error  = resp_err;
        if (last_op == 3'h4) begin
          tl_i.d_opcode = 3'h1;
          tl_i.d_data   = mem[fire_addr[7:2]];
        end else begin
          tl_i.d_opcode = 3'h0;
          tl_i.d_data   = 32'hDEAD_BEEF;
          if (!resp_err)
            for (int b = 0; b < 4; b++)
              if (last_mask[b]) mem[fire_addr[7:2]][8*b +: 8] = fire_data[8*b +: 8];
        end
      end
      if (inject_late) begin
        inject_late   = 0;
        tl_i.d_valid  = 1'b1;
        tl_i.d_opcode = 3'h1;
        tl_i.d_source = 8'h00;
        tl_i.d_error  = 1'b0;
        tl_i.d_data   = 32'h0BAD_0BAD;
      end
      cur_a = {tl_o.a_opcode, tl_o.a_size, tl_o.a_source, tl_o.a_address,
               tl_o.a_mask, tl_o.a_data, tl_o.a_user};
      if (tl_o.a_valid) begin
        av_cycles++;
        if (!prev_av) stall_left = stall_cfg;
        if (prev_stall && (cur_a !== prev_a)) a_unstable++;
        if (stall_left > 0) begin
          tl_i.a_ready = 1'b0;
          stall_left--;
        end else begin
          tl_i.a_ready = 1'b1;
        end
      end else begin
        tl_i.a_ready = 1'b0;
      end
      a_fire     = tl_o.a_valid && tl_i.a_ready;
      prev_stall = tl_o.a_valid && !tl_i.a_ready;
      prev_av    = tl_o.a_valid;
      prev_a     = cur_a;
      if (a_fire) begin
        a_beats++;
        last_op    = tl_o.a_opcode;
        last_mask  = tl_o.a_mask;
        last_size  = tl_o.a_size;
        last_src   = tl_o.a_source;
        last_itype = tl_o.a_user.instr_type;
        fire_addr  = tl_o.a_address;
        fire_data  = tl_o.a_data;
      end
      d_fire      = tl_i.d_valid && tl_o.d_ready;
      d_fire_idle = d_fire && !busy;
    end
  end

  // Issues one command, waits for its response, optionally holds rsp_ready low for `hold` cycles.
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold,
                        output logic [2:0] err, output logic [31:0] rdata, output int lat,
                        output int av_lat, output int unstable, output bit rdy_after);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk_eq("cmd_accept_bound", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    av_lat = -1;
    while (!rsp_valid && lat < 200) begin
      if (tl_o.a_valid && av_lat < 0) av_lat = lat;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk_eq("rsp_wait_bound", 0, 1);
    err = rsp_err;
    rdata = rsp_rdata;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_err !== err || rsp_rdata !== rdata || cmd_ready) unstable++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    rdy_after = cmd_ready && !rsp_valid;
  endtask

  logic [2:0]  e;
  logic [31:0] rd;
  int          lat, avl, unst, beats0, av0, unst0, drain0, rsp_seen;
  bit          rdy;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1] = 32'h0000_0001;
    repeat (3) @(negedge clk);
    chk_eq("rst_cmd_ready", cmd_ready, 0);
    chk_eq("rst_rsp_valid", rsp_valid, 0);
    chk_eq("rst_a_valid", tl_o.a_valid, 0);
    chk_eq("rst_d_ready", tl_o.d_ready, 1);
    chk_eq("rst_rsp_err", rsp_err, 0);
    chk_eq("rst_rsp_rdata", rsp_rdata, 0);
    chk_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("idle_cmd_ready", cmd_ready, 1);

    // 1: basic read, latency and A fields
    do_cmd(0, 32'h4, 32'h0, 4'h0, 0, e, rd, lat, avl, unst, rdy);
    chk_eq("rd_lat", lat, 3);
    chk_eq("rd_a_lat", avl, 1);
    chk_eq("rd_err", e, 0);
    chk_eq("rd_data", rd, 32'h1);
    chk_eq("rd_opcode", last_op, 3'h4);
    chk_eq("rd_mask", last_mask, 4'hF);
    chk_eq("rd_size", last_size, 2'd2);
    chk_eq("rd_source", last_src, 8'h00);
    chk_eq("rd_instr_type", last_itype, 4'h9);
    chk_eq("rd_next_ready", rdy, 1);

    // 2: full write then read back
    do_cmd(1, 32'h34, 32'h0000_1000, 4'hF, 0, e, rd, lat, avl, unst, rdy);
    chk_eq("wf_opcode", last_op, 3'h0);
    chk_eq("wf_err", e, 0);
    chk_eq("wf_rdata", rd, 0);
    do_cmd(0, 32'h34, 32'h0, 4'h0, 0, e, rd, lat, avl, unst, rdy);
    chk_eq("wf_readback", rd, 32'h0000_1000);

    // 3: partial write with a 5-cycle a_ready stall
    stall_cfg = 5;
    beats0 = a_beats; av0 = av_cycles; unst0 = a_unstable;
    do_cmd(1, 32'h38, 32'hAAAA_5555, 4'b0011, 0, e, rd, lat, avl, unst, rdy);
    chk_eq("wp_opcode", last_op, 3'h1);
    chk_eq("wp_mask", last_mask, 4'h3);
    chk_eq("wp_beats", a_beats - beats0, 1);
    chk_eq("wp_av_cycles", av_cycles - av0, 6);
    chk_eq("wp_a_stable", a_unstable - unst0, 0);
    chk_eq("wp_err", e, 0);
    stall_cfg = 0;
    do_cmd(0, 32'h38, 32'h0, 4'h0, 0, e, rd, lat, avl, unst, rdy);
    chk_eq("wp_readback", rd, 32'h0000_5555);

    // 4: misaligned read never reaches the bus
    beats0 = a_beats; av0 = av_cycles;
    do_cmd(0, 32'h6, 32'h0, 4'h0, 0, e, rd, lat, avl, unst, rdy);
    chk_eq("mis_err", e, 3'd4);
    chk_eq("mis_rdata", rd, 0);
    chk_eq("mis_no_a_valid", av_cycles - av0, 0);
    chk_eq("mis_no_beats", a_beats - beats0, 0);
    chk_eq("mis_next_ready", rdy, 1);

    // 5: bus error, then wrong source
    resp_err = 1;
    do_cmd(0, 32'h4, 32'h0, 4'h0, 0, e, rd, lat, avl, unst, rdy);
    chk_eq("bus_err", e, 3'd1);
    chk_eq("bus_rdata", rd, 0);
    resp_err = 0;
    resp_src = 8'h05;
    do_cmd(0, 32'h4, 32'h0, 4'h0, 0, e, rd, lat, avl, unst, rdy);
    chk_eq("proto_err", e, 3'd2);
    chk_eq("proto_rdata", rd, 0);
    resp_src = 8'h00;

    // 6: timeout, late response drained, then timeout with held rsp_ready
    no_resp = 1;
    do_cmd(0, 32'h4, 32'h0, 4'h0, 0, e, rd, lat, avl, unst, rdy);
    chk_eq("to_err", e, 3'd3);
    chk_eq("to_rdata", rd, 0);
    chk_eq("to_cycles", lat - avl, 16);
    drain0 = d_drained;
    rsp_seen = 0;
    repeat (3) @(negedge clk);
    inject_late = 1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    chk_eq("late_drained", d_drained - drain0, 1);
    chk_eq("late_no_rsp", rsp_seen, 0);
    do_cmd(0, 32'h4, 32'h0, 4'h0, 10, e, rd, lat, avl, unst, rdy);
    chk_eq("to2_err", e, 3'd3);
    chk_eq("to2_cycles", lat - avl, 16);
    chk_eq("to2_stable", unst, 0);
    no_resp = 0;
    do_cmd(0, 32'h34, 32'h0, 4'h0, 0, e, rd, lat, avl, unst, rdy);
    chk_eq("recover_data", rd, 32'h0000_1000);
    chk_eq("recover_err", e, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
